// File: rtl/mux_pkg.sv
// Shared types for the scanning N:1 multiplexer: scan FSM states and mode encodings.
package mux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      EMIT  = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/next_ch_sel.sv
// Round-robin helper: next set mask bit strictly above cur_i, wrapping to the lowest set bit.
// low_o is the lowest set bit on its own; none_o flags an all-zero mask (both indices are 0 then).
module next_ch_sel #(
   parameter int N    = 8,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    mask_i,
   input  logic [SELW-1:0] cur_i,
   output logic [SELW-1:0] nxt_o,
   output logic [SELW-1:0] low_o,
   output logic            none_o
);

   logic hit;

   always_comb begin
      nxt_o  = '0;
      low_o  = '0;
      none_o = 1'b1;
      hit    = 1'b0;
      // Descending scans so the last match is the lowest qualifying index.
      for (int k = N - 1; k >= 0; k--) begin
         if (mask_i[k]) begin
            low_o  = SELW'(k);
            none_o = 1'b0;
         end
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (mask_i[k] && (k > int'(cur_i))) begin
            nxt_o = SELW'(k);
            hit   = 1'b1;
         end
      end
      if (!hit) begin
         nxt_o = low_o;
      end
   end

endmodule

// File: rtl/mux_scan_nx1.sv
// N-channel W-bit mux with a registered valid/ready output; direct select or
// autonomous round-robin scan over enabled channels with a programmable dwell.
module mux_scan_nx1
   import mux_pkg::*;
#(
   parameter int N      = 8,
   parameter int W      = 8,
   parameter int SELW   = $clog2(N),
   parameter int DWELLW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N*W-1:0]    din,
   input  logic [SELW-1:0]   sel,
   input  logic              mode,
   input  logic [N-1:0]      ch_mask,
   input  logic [DWELLW-1:0] dwell,
   input  logic              start,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   state_e            state_q, state_d;
   logic [DWELLW-1:0] cnt_q, cnt_d;
   logic [SELW-1:0]   ptr_q, ptr_d;
   logic [W-1:0]      data_q, data_d;
   logic [SELW-1:0]   ch_q, ch_d;
   logic              valid_q, valid_d;

   logic              free;
   logic [SELW-1:0]   nxt_ch;
   logic [SELW-1:0]   low_ch;
   logic              mask_none;

   // Out-of-range indices (possible when N is not a power of two) read as zero.
   function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus,
                                         input logic [SELW-1:0] idx);
      pick = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == SELW'(k)) begin
            pick = bus[k*W +: W];
         end
      end
   endfunction

   assign free = !valid_q || out_ready;

   next_ch_sel #(
      .N    (N),
      .SELW (SELW)
   ) u_next_ch_sel (
      .mask_i (ch_mask),
      .cur_i  (ptr_q),
      .nxt_o  (nxt_ch),
      .low_o  (low_ch),
      .none_o (mask_none)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if ((mode == MODE_SCAN) && start && !mask_none) begin
               ptr_d   = low_ch;
               cnt_d   = dwell;
               state_d = DWELL;
            end
         end
         DWELL: begin
            // Leave once the decremented count reaches zero: one sample every dwell+1 cycles, min 2.
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            if (cnt_q <= DWELLW'(1)) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (free) begin
               ptr_d = nxt_ch;
               if ((mode == MODE_SCAN) && !mask_none) begin
                  cnt_d   = dwell;
                  state_d = DWELL;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = valid_q && !out_ready;
      busy    = (state_q != IDLE);
      if ((state_q == IDLE) && (mode == MODE_DIRECT) && free) begin
         data_d  = pick(din, sel);
         ch_d    = sel;
         valid_d = 1'b1;
      end else if ((state_q == EMIT) && free) begin
         data_d  = pick(din, ptr_q);
         ch_d    = ptr_q;
         valid_d = 1'b1;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1 (N=8, W=8): reset, direct capture, backpressure,
// scan wrap, EMIT stall, mode drop, single-channel dwell=0 and empty-mask start.
module tb_mux_scan_nx1;

   localparam int N      = 8;
   localparam int W      = 8;
   localparam int SELW   = 3;
   localparam int DWELLW = 8;

   logic              clk;
   logic              rst_n;
   logic [N*W-1:0]    din;
   logic [SELW-1:0]   sel;
   logic              mode;
   logic [N-1:0]      ch_mask;
   logic [DWELLW-1:0] dwell;
   logic              start;
   logic [W-1:0]      out_data;
   logic [SELW-1:0]   out_ch;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   mux_scan_nx1 #(
      .N      (N),
      .W      (W),
      .SELW   (SELW),
      .DWELLW (DWELLW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .sel       (sel),
      .mode      (mode),
      .ch_mask   (ch_mask),
      .dwell     (dwell),
      .start     (start),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [SELW-1:0] ch,
                             input logic [W-1:0] d, input logic b);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".ch"},    32'(out_ch),    32'(ch));
      check({tag, ".data"},  32'(out_data),  32'(d));
      check({tag, ".busy"},  32'(busy),      32'(b));
   endtask

   task automatic expect_gap(input string tag, input logic b);
      check({tag, ".valid"}, 32'(out_valid), 32'd0);
      check({tag, ".busy"},  32'(busy),      32'(b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [SELW-1:0] scan_ch  [5];
   logic [W-1:0]    scan_dat [5];

   initial begin
      // channel k data: ch0=5A ch1=11 ch2=22 ch3=A5 ch4=44 ch5=55 ch6=66 ch7=77
      din       = {8'h77, 8'h66, 8'h55, 8'h44, 8'hA5, 8'h22, 8'h11, 8'h5A};
      rst_n     = 1'b0;
      sel       = '0;
      mode      = 1'b0;
      ch_mask   = 8'h85;
      dwell     = '0;
      start     = 1'b0;
      out_ready = 1'b1;
      scan_ch   = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
      scan_dat  = '{8'h5A, 8'h22, 8'h77, 8'h5A, 8'h22};

      repeat (2) tick();
      expect_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);

      rst_n = 1'b1;
      sel   = 3'd5;
      tick();
      expect_out("direct5", 1'b1, 3'd5, 8'h55, 1'b0);

      rst_n = 1'b0;
      #2;
      expect_out("async_reset", 1'b0, 3'd0, 8'h00, 1'b0);
      #2;
      rst_n = 1'b1;
      sel   = 3'd3;
      tick();
      expect_out("direct3", 1'b1, 3'd3, 8'hA5, 1'b0);

      // start has no effect in direct mode
      sel   = 3'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_out("direct1", 1'b1, 3'd1, 8'h11, 1'b0);

      out_ready = 1'b0;
      sel       = 3'd2;
      repeat (4) begin
         tick();
         expect_out("bp_hold", 1'b1, 3'd1, 8'h11, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      expect_out("bp_release", 1'b1, 3'd2, 8'h22, 1'b0);

      mode    = 1'b1;
      ch_mask = 8'b1000_0101;
      dwell   = 8'd2;
      start   = 1'b1;
      tick();
      start = 1'b0;
      expect_gap("scan_start", 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_gap("scan_gap_a", 1'b1);
         tick();
         expect_gap("scan_gap_b", 1'b1);
         tick();
         expect_out($sformatf("scan%0d", i), 1'b1, scan_ch[i], scan_dat[i], 1'b1);
      end

      out_ready = 1'b0;
      repeat (7) begin
         tick();
         expect_out("emit_stall", 1'b1, 3'd2, 8'h22, 1'b1);
      end
      out_ready = 1'b1;
      tick();
      expect_out("stall_release", 1'b1, 3'd7, 8'h77, 1'b1);
      tick();
      expect_gap("post_stall_a", 1'b1);
      tick();
      expect_gap("post_stall_b", 1'b1);
      tick();
      expect_out("post_stall", 1'b1, 3'd0, 8'h5A, 1'b1);

      mode = 1'b0;
      sel  = 3'd4;
      tick();
      expect_gap("drop_a", 1'b1);
      tick();
      expect_gap("drop_b", 1'b1);
      tick();
      expect_out("drop_last", 1'b1, 3'd2, 8'h22, 1'b0);
      tick();
      expect_out("drop_direct", 1'b1, 3'd4, 8'h44, 1'b0);

      mode    = 1'b1;
      ch_mask = 8'b0001_0000;
      dwell   = 8'd0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      expect_gap("single_start", 1'b1);
      repeat (3) begin
         tick();
         expect_gap("single_gap", 1'b1);
         tick();
         expect_out("single", 1'b1, 3'd4, 8'h44, 1'b1);
      end

      rst_n = 1'b0;
      #2;
      expect_out("reset_mid_scan", 1'b0, 3'd0, 8'h00, 1'b0);
      #2;
      rst_n   = 1'b1;
      mode    = 1'b1;
      ch_mask = 8'h00;
      start   = 1'b1;
      tick();
      start = 1'b0;
      expect_gap("empty_mask", 1'b0);
      repeat (3) tick();
      expect_gap("empty_mask_later", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
